interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 180 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Machine-mode interrupt controller: 64-bit timer (MTIP), software
// interrupt bit (MSIP) and an external-source gateway/claim unit (MEIP),
// all behind a small memory-mapped register port.

// Per-source gateway: rising-edge capture into pending, claim/complete
// handshake through in_service.
module interrupt_gateway (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic src_q;
  logic rise;

  assign rise = src & ~src_q;

  // Edge history, pending and in-service state; a claim in the same cycle
  // as a new edge wins and the edge is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q      <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      src_q      <= src;
      pending    <= (pending | (rise & ~in_service)) & ~claim;
      in_service <= (in_service | claim) & ~complete;
    end
  end

endmodule

module interrupt_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [31:0]        irq_o
);

  localparam logic [5:0] A_MSIP        = 6'd0;
  localparam logic [5:0] A_MTIME_LO    = 6'd1;
  localparam logic [5:0] A_MTIME_HI    = 6'd2;
  localparam logic [5:0] A_MTIMECMP_LO = 6'd3;
  localparam logic [5:0] A_MTIMECMP_HI = 6'd4;
  localparam logic [5:0] A_ENABLE      = 6'd5;
  localparam logic [5:0] A_PENDING     = 6'd6;
  localparam logic [5:0] A_CLAIM       = 6'd7;

  logic [5:0]         reg_idx;
  logic               wr, rd;
  logic               msip;
  logic [63:0]        mtime, mtime_inc, mtimecmp;
  logic [NUM_SRC-1:0] enable, pending, in_service, pend_en;
  logic [NUM_SRC-1:0] claim_vec, complete_vec;
  logic [4:0]         claim_id;
  logic               mtip_q, meip_q;
  logic [31:0]        rd_data;
  logic               unused_addr;

  // Registers are word aligned; the byte offset bits carry no meaning.
  assign unused_addr = ^addr_i[1:0];
  assign reg_idx     = addr_i[7:2];
  assign wr          = en_i & we_i;
  assign rd          = en_i & ~we_i;
  assign mtime_inc   = mtime + 64'd1;
  assign pend_en     = pending & enable;

  // Lowest-numbered pending and enabled source wins; ID is index + 1.
  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend_en[i]) claim_id = 5'(i + 1);
  end

  // One-hot claim and complete strobes; completes of IDs not in service
  // (including 0 and out-of-range values) decode to nothing.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i]    = rd && (reg_idx == A_CLAIM) && (claim_id == 5'(i + 1));
      complete_vec[i] = wr && (reg_idx == A_CLAIM) && (data_i == 32'(i + 1))
                        && in_service[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    interrupt_gateway u_gw (
      .clk        (clk),
      .reset      (reset),
      .src        (src_i[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  // Free-running timer; a written half takes the bus value, so a carry
  // out of LO into a written HI is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime <= '0;
    end else begin
      mtime[31:0]  <= (wr && reg_idx == A_MTIME_LO) ? data_i : mtime_inc[31:0];
      mtime[63:32] <= (wr && reg_idx == A_MTIME_HI) ? data_i : mtime_inc[63:32];
    end
  end

  // Plain software-visible control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip     <= 1'b0;
      mtimecmp <= '1;
      enable   <= '0;
    end else if (wr) begin
      case (reg_idx)
        A_MSIP:        msip            <= data_i[0];
        A_MTIMECMP_LO: mtimecmp[31:0]  <= data_i;
        A_MTIMECMP_HI: mtimecmp[63:32] <= data_i;
        A_ENABLE:      enable          <= data_i[NUM_SRC-1:0];
        default: ;
      endcase
    end
  end

  // Read mux; unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      A_MSIP:        rd_data[0]           = msip;
      A_MTIME_LO:    rd_data              = mtime[31:0];
      A_MTIME_HI:    rd_data              = mtime[63:32];
      A_MTIMECMP_LO: rd_data              = mtimecmp[31:0];
      A_MTIMECMP_HI: rd_data              = mtimecmp[63:32];
      A_ENABLE:      rd_data[NUM_SRC-1:0] = enable;
      A_PENDING:     rd_data[NUM_SRC-1:0] = pending;
      A_CLAIM:       rd_data[4:0]         = claim_id;
      default:       rd_data              = '0;
    endcase
  end

  // Read data register: loads on a read, holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   data_o <= '0;
    else if (rd) data_o <= rd_data;
  end

  // Registered timer compare and external interrupt summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtip_q <= 1'b0;
      meip_q <= 1'b0;
    end else begin
      mtip_q <= (mtime >= mtimecmp);
      meip_q <= |pend_en;
    end
  end

  // mip-format vector: MEIP bit 11, MTIP bit 7, MSIP bit 3.
  always_comb begin
    irq_o     = '0;
    irq_o[11] = meip_q;
    irq_o[7]  = mtip_q;
    irq_o[3]  = msip;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int NUM_SRC = 8;
  localparam logic [7:0] R_MSIP = 8'h00, R_MT_LO = 8'h04, R_MT_HI = 8'h08,
                         R_CMP_LO = 8'h0C, R_CMP_HI = 8'h10, R_EN = 8'h14,
                         R_PEND = 8'h18, R_CLAIM = 8'h1C;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_SRC-1:0] src_i = '0;
  logic               en_i = 1'b0, we_i = 1'b0;
  logic [7:0]         addr_i = '0;
  logic [31:0]        data_i = '0;
  logic [31:0]        data_o, irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    string       tag;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;
  logic rd_issued;

  interrupt_controller #(.NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .reset(reset), .src_i(src_i), .en_i(en_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Track which edges carried a read so the scoreboard knows when data_o is fresh.
  always @(posedge clk or posedge reset) begin
    if (reset) rd_issued <= 1'b0;
    else       rd_issued <= en_i && !we_i;
  end

  // Scoreboard: pop the expectation pushed when the read was issued.
  always @(negedge clk) begin
    if (rd_issued) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: data_o=%h with no expected value queued", data_o);
      end else begin
        sb_e = sb_q.pop_front();
        if (data_o !== sb_e.data) begin
          n_fail++;
          $display("FAIL %s: data_o=%h expected %h", sb_e.tag, data_o, sb_e.data);
        end
      end
    end
  end

  // Bus tasks: entered at a negedge, each consumes exactly one rising edge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    en_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    e.data = exp; e.tag = tag;
    sb_q.push_back(e);
    en_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    en_i = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    src_i = m;
    @(negedge clk);
    src_i = '0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; en_i = 1'b0; we_i = 1'b0; src_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h0) begin n_fail++; $display("FAIL reset_irq: irq_o=%h expected 0", irq_o); end
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: data_o=%h expected 0", data_o); end
    reset = 1'b0;
    bus_read(R_MT_LO, 32'h0, "reset_mtime_lo");
    bus_read(R_CMP_LO, 32'hFFFF_FFFF, "reset_cmp_lo");
    bus_read(R_CMP_HI, 32'hFFFF_FFFF, "reset_cmp_hi");
    bus_read(R_MSIP, 32'h0, "reset_msip");
    bus_read(R_EN, 32'h0, "reset_enable");
    bus_read(R_PEND, 32'h0, "reset_pending");
    bus_write(8'h20, 32'hDEAD_BEEF);
    bus_read(8'h20, 32'h0, "unmapped_20");
    bus_read(8'hFC, 32'h0, "unmapped_fc");
  endtask

  task automatic test_timer();
    apply_reset();
    bus_write(R_CMP_HI, 32'h0);   // edge 1, mtime -> 1
    bus_write(R_CMP_LO, 32'd20);  // edge 2, mtime -> 2
    repeat (18) @(negedge clk);   // edge 20: mtime == 20, compare not yet registered
    n_checks++;
    if (irq_o[7] !== 1'b0) begin n_fail++; $display("FAIL mtip_early: irq_o[7]=%b expected 0", irq_o[7]); end
    @(negedge clk);
    n_checks++;
    if (irq_o[7] !== 1'b1) begin n_fail++; $display("FAIL mtip_set: irq_o[7]=%b expected 1", irq_o[7]); end
    bus_write(R_CMP_LO, 32'hFFFF_FFFF);
    n_checks++;
    if (irq_o[7] !== 1'b1) begin n_fail++; $display("FAIL mtip_hold: irq_o[7]=%b expected 1", irq_o[7]); end
    @(negedge clk);
    n_checks++;
    if (irq_o[7] !== 1'b0) begin n_fail++; $display("FAIL mtip_clear: irq_o[7]=%b expected 0", irq_o[7]); end
  endtask

  task automatic test_software();
    bus_write(R_MSIP, 32'h1);
    n_checks++;
    if (irq_o !== 32'h8) begin n_fail++; $display("FAIL msip_set: irq_o=%h expected 00000008", irq_o); end
    bus_read(R_MSIP, 32'h1, "msip_readback");
    bus_write(R_MSIP, 32'h0);
    n_checks++;
    if (irq_o !== 32'h0) begin n_fail++; $display("FAIL msip_clear: irq_o=%h expected 0", irq_o); end
  endtask

  task automatic test_priority();
    bus_write(R_EN, 32'hFF);
    pulse(8'h24);
    n_checks++;
    if (irq_o[11] !== 1'b1) begin n_fail++; $display("FAIL meip_set: irq_o[11]=%b expected 1", irq_o[11]); end
    bus_read(R_PEND, 32'h24, "prio_pending");
    bus_read(R_CLAIM, 32'd3, "prio_claim_first");
    bus_read(R_CLAIM, 32'd6, "prio_claim_second");
    bus_read(R_CLAIM, 32'd0, "prio_claim_none");
    n_checks++;
    if (irq_o[11] !== 1'b0) begin n_fail++; $display("FAIL meip_drop: irq_o[11]=%b expected 0", irq_o[11]); end
    bus_write(R_CLAIM, 32'd3);
    bus_write(R_CLAIM, 32'd6);
  endtask

  task automatic test_gateway();
    pulse(8'h02);
    bus_read(R_CLAIM, 32'd2, "gw_claim");
    pulse(8'h02);
    bus_read(R_PEND, 32'h00, "gw_drop_in_service");
    bus_write(R_CLAIM, 32'd2);
    pulse(8'h02);
    bus_read(R_PEND, 32'h02, "gw_after_complete");
    bus_read(R_CLAIM, 32'd2, "gw_reclaim");
    // level held high across several edges must register once
    src_i = 8'h10;
    repeat (3) @(negedge clk);
    bus_read(R_CLAIM, 32'd5, "gw_level_claim");
    repeat (2) @(negedge clk);
    bus_read(R_PEND, 32'h00, "gw_level_no_retrigger");
    src_i = '0;
    bus_write(R_CLAIM, 32'd5);
    // claim colliding with a fresh edge on the same source
    pulse(8'h01);
    src_i = 8'h01;
    bus_read(R_CLAIM, 32'd1, "gw_collide_claim");
    src_i = '0;
    bus_read(R_PEND, 32'h00, "gw_collide_pending");
    bus_write(R_CLAIM, 32'd1);
  endtask

  task automatic test_bad_complete();
    // ID 2 is still in service from the gateway test
    bus_write(R_CLAIM, 32'd7);
    pulse(8'h02);
    bus_read(R_PEND, 32'h00, "bad_complete_7");
    bus_write(R_CLAIM, 32'd0);
    pulse(8'h02);
    bus_read(R_PEND, 32'h00, "bad_complete_0");
    bus_write(R_CLAIM, 32'd2);
    pulse(8'h02);
    bus_read(R_PEND, 32'h02, "good_complete_2");
    bus_write(R_EN, 32'h00);
    @(negedge clk);
    n_checks++;
    if (irq_o[11] !== 1'b0) begin n_fail++; $display("FAIL meip_masked: irq_o[11]=%b expected 0", irq_o[11]); end
    bus_read(R_PEND, 32'h02, "disable_keeps_pending");
    bus_read(R_CLAIM, 32'd0, "disable_claim_none");
    bus_write(R_EN, 32'hFF);
    bus_read(R_CLAIM, 32'd2, "reenable_claim");
    bus_write(R_CLAIM, 32'd2);
  endtask

  task automatic test_mtime_edges();
    bus_write(R_MT_HI, 32'h0);
    bus_write(R_MT_LO, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_read(R_MT_HI, 32'h1, "mtime_carry_hi");
    bus_read(R_MT_LO, 32'h1, "mtime_carry_lo");
    bus_write(R_MT_LO, 32'hFFFF_FFFF);
    bus_write(R_MT_HI, 32'h5);
    bus_read(R_MT_HI, 32'h5, "mtime_carry_discarded");
    bus_write(R_MT_HI, 32'hFFFF_FFFF);
    bus_write(R_MT_LO, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_read(R_MT_HI, 32'h0, "mtime_wrap_hi");
    bus_read(R_MT_LO, 32'h1, "mtime_wrap_lo");
  endtask

  task automatic test_reset_midclaim();
    pulse(8'h01);
    src_i = 8'h01;
    bus_read(R_CLAIM, 32'd1, "midclaim_claim");
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (irq_o !== 32'h0) begin n_fail++; $display("FAIL midreset_irq: irq_o=%h expected 0", irq_o); end
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL midreset_data: data_o=%h expected 0", data_o); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(R_PEND, 32'h01, "midreset_pending");
    bus_read(R_EN, 32'h00, "midreset_enable");
    src_i = '0;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_software();
    test_priority();
    test_gateway();
    test_bad_complete();
    test_mtime_edges();
    test_reset_midclaim();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d reads never returned, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
